// File: rtl/bcd_count_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : bcd_count_ctrl_if
// Brief    : Control and display bundle for the four-digit BCD counter
//            controller. The master drives start/stop/clear. The slave
//            (the controller) returns status, the count value and the
//            multiplexed display lines.
// Revision : 1.0 - initial release
// ============================================================================
interface bcd_count_ctrl_if;
    logic        start;
    logic        stop;
    logic        clear;
    logic        run;
    logic        done;
    logic        tick;
    logic [15:0] count;
    logic [3:0]  digit_sel;
    logic [3:0]  digit_bcd;

    modport master (
        output start, stop, clear,
        input  run, done, tick, count, digit_sel, digit_bcd
    );

    modport slave (
        input  start, stop, clear,
        output run, done, tick, count, digit_sel, digit_bcd
    );
endinterface
`default_nettype wire

// File: rtl/bcd_count_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bcd_count_ctrl
// Brief    : Run/pause/clear/terminal sequencer for a four-digit BCD counting
//            chain. A prescaler divides clk into count ticks. A second,
//            free-running prescaler time-multiplexes one BCD-to-7-segment
//            decoder across four active-low anodes.
//            Optional feature macro: BCD_COUNT_CTRL_BLANK_EN. When it is
//            defined, leading zeros on digits 1..3 are blanked.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_count_ctrl #(
    parameter int TICK_DIV = 100_000_000,
    parameter int SCAN_DIV = 100_000
) (
    input  wire logic       clk,
    input  wire logic       reset,
    bcd_count_ctrl_if.slave bus
);

    localparam int c_tick_w = $clog2(TICK_DIV);
    localparam int c_scan_w = $clog2(SCAN_DIV);
    localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(TICK_DIV - 1);
    localparam logic [c_scan_w-1:0] c_scan_last = c_scan_w'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [c_tick_w-1:0]   psc_q, psc_d;
    logic [15:0]           count_q, count_d;
    logic                  tick_q, tick_d;
    logic                  run_q, run_d;
    logic                  done_q, done_d;
    logic [c_scan_w-1:0]   scan_q, scan_d;
    logic [1:0]            idx_q, idx_d;
    logic [3:0]            sel_q, sel_d;
    logic [15:0]           w_count_inc;
    logic [3:0]            w_digit_bcd;

    // Ripple a +1 through four BCD digits. A digit moves only when every
    // lower digit was 9. Because the sequencer stops at 9999, no wrap occurs.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

`ifdef BCD_COUNT_CTRL_BLANK_EN
    // A slot is blank when its digit and all higher digits are zero.
    // Digit 0 always shows, so a zero count still displays "0".
    function automatic logic is_blank(input logic [1:0] idx, input logic [15:0] cnt);
        logic b;
        case (idx)
            2'd1:    b = (cnt[15:4]  == 12'h000);
            2'd2:    b = (cnt[15:8]  == 8'h00);
            2'd3:    b = (cnt[15:12] == 4'h0);
            default: b = 1'b0;
        endcase
        return b;
    endfunction
`endif

    assign w_count_inc = bcd_inc(count_q);

    // Sequencer next state: clear beats stop, and stop beats start.
    // The tick prescaler freezes whenever it is not advancing in RUN.
    always_comb begin
        state_d = state_q;
        psc_d   = psc_q;
        count_d = count_q;
        tick_d  = 1'b0;
        if (bus.clear) begin
            state_d = ST_IDLE;
            psc_d   = '0;
            count_d = 16'h0000;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    psc_d = '0;
                    if (bus.start && !bus.stop) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.stop) begin
                        state_d = ST_PAUSE;
                    end else if (psc_q == c_tick_last) begin
                        psc_d   = '0;
                        count_d = w_count_inc;
                        tick_d  = 1'b1;
                        if (w_count_inc == 16'h9999) begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        psc_d = psc_q + 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (bus.start && !bus.stop) begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        run_d  = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // Free-running scan timebase. The anode enable is registered from the
    // next index and count, so it lines up with the combinational digit mux.
    always_comb begin
        scan_d = scan_q;
        idx_d  = idx_q;
        if (scan_q == c_scan_last) begin
            scan_d = '0;
            idx_d  = idx_q + 2'd1;
        end else begin
            scan_d = scan_q + 1'b1;
        end
`ifdef BCD_COUNT_CTRL_BLANK_EN
        sel_d = is_blank(idx_d, count_d) ? 4'b1111 : ~(4'b0001 << idx_d);
`else
        sel_d = ~(4'b0001 << idx_d);
`endif
    end

    // Route the selected digit to the shared decoder.
    always_comb begin
        w_digit_bcd = count_q[{idx_q, 2'b00} +: 4];
`ifdef BCD_COUNT_CTRL_BLANK_EN
        if (is_blank(idx_q, count_q)) begin
            w_digit_bcd = 4'hF;
        end
`endif
    end

    // All state registers. Reset is synchronous and active-low.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            psc_q   <= '0;
            count_q <= 16'h0000;
            tick_q  <= 1'b0;
            run_q   <= 1'b0;
            done_q  <= 1'b0;
            scan_q  <= '0;
            idx_q   <= 2'd0;
            sel_q   <= 4'b1110;
        end else begin
            state_q <= state_d;
            psc_q   <= psc_d;
            count_q <= count_d;
            tick_q  <= tick_d;
            run_q   <= run_d;
            done_q  <= done_d;
            scan_q  <= scan_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
        end
    end

    assign bus.run       = run_q;
    assign bus.done      = done_q;
    assign bus.tick      = tick_q;
    assign bus.count     = count_q;
    assign bus.digit_sel = sel_q;
    assign bus.digit_bcd = w_digit_bcd;

endmodule
`default_nettype wire

// File: tb/tb_bcd_count_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_count_ctrl
// Brief    : Directed self-checking bench for bcd_count_ctrl. It uses
//            TICK_DIV=4 and SCAN_DIV=2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_count_ctrl;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_bad;

    bcd_count_ctrl_if bus_if ();

    bcd_count_ctrl #(
        .TICK_DIV (4),
        .SCAN_DIV (2)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it on mismatch.
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_clear();
        bus_if.clear = 1'b1;
        step(1);
        bus_if.clear = 1'b0;
    endtask

    task automatic pulse_start();
        bus_if.start = 1'b1;
        step(1);
        bus_if.start = 1'b0;
    endtask

    // Clear, start, count n ticks (4 edges each), then pause.
    task automatic run_to(input int n);
        pulse_clear();
        pulse_start();
        step(4 * n);
        bus_if.stop = 1'b1;
        step(1);
        bus_if.stop = 1'b0;
    endtask

    // Wait for the transition prev_sel -> 1110, then check 8 cycles. Nibble k
    // of exp_sel/exp_bcd holds the expected value for slot k.
    task automatic scan8(input logic [3:0] prev_sel, input logic [15:0] exp_sel,
                         input logic [15:0] exp_bcd);
        logic [3:0] prev;
        logic       found;
        int         slot;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            prev = bus_if.digit_sel;
            step(1);
            if (prev == prev_sel && bus_if.digit_sel == 4'b1110) found = 1'b1;
        end
        check_val("scan_sync", {31'd0, found}, 32'd1);
        if (found) begin
            for (int i = 0; i < 8; i++) begin
                slot = i / 2;
                check_val($sformatf("scan_sel_%0d", i), {28'd0, bus_if.digit_sel},
                          {28'd0, exp_sel[4*slot +: 4]});
                check_val($sformatf("scan_bcd_%0d", i), {28'd0, bus_if.digit_bcd},
                          {28'd0, exp_bcd[4*slot +: 4]});
                step(1);
            end
        end
    endtask

    // A global time limit keeps the run bounded.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // Directed scenario sequence.
    initial begin
        int done_k;
        int errs;
        n_checks     = 0;
        n_bad        = 0;
        reset        = 1'b0;
        bus_if.start = 1'b0;
        bus_if.stop  = 1'b0;
        bus_if.clear = 1'b0;

        // Power-on reset values
        step(2);
        check_val("rst_count", {16'd0, bus_if.count}, 32'h0);
        check_val("rst_run",   {31'd0, bus_if.run}, 32'd0);
        check_val("rst_done",  {31'd0, bus_if.done}, 32'd0);
        check_val("rst_tick",  {31'd0, bus_if.tick}, 32'd0);
        check_val("rst_sel",   {28'd0, bus_if.digit_sel}, 32'hE);
        check_val("rst_bcd",   {28'd0, bus_if.digit_bcd}, 32'h0);

        // Counting: a tick every 4 edges after the start edge, with carries
        reset = 1'b1;
        pulse_start();
        check_val("start_run", {31'd0, bus_if.run}, 32'd1);
        for (int k = 1; k <= 400; k++) begin
            step(1);
            if (k <= 40)
                check_val($sformatf("tick_k%0d", k), {31'd0, bus_if.tick},
                          {31'd0, (k % 4) == 0});
            if (k == 39)  check_val("cnt_0009", {16'd0, bus_if.count}, 32'h0009);
            if (k == 40)  check_val("cnt_0010", {16'd0, bus_if.count}, 32'h0010);
            if (k == 399) check_val("cnt_0099", {16'd0, bus_if.count}, 32'h0099);
            if (k == 400) check_val("cnt_0100", {16'd0, bus_if.count}, 32'h0100);
        end

        // Reset mid-RUN at count 0x0037
        pulse_clear();
        pulse_start();
        step(148);
        check_val("pre_rst_cnt", {16'd0, bus_if.count}, 32'h0037);
        check_val("pre_rst_run", {31'd0, bus_if.run}, 32'd1);
        reset = 1'b0;
        step(2);
        check_val("mid_rst_count", {16'd0, bus_if.count}, 32'h0);
        check_val("mid_rst_run",   {31'd0, bus_if.run}, 32'd0);
        check_val("mid_rst_done",  {31'd0, bus_if.done}, 32'd0);
        check_val("mid_rst_tick",  {31'd0, bus_if.tick}, 32'd0);
        check_val("mid_rst_sel",   {28'd0, bus_if.digit_sel}, 32'hE);
        reset = 1'b1;

        // Pause at count 3 with prescaler 2, then resume
        pulse_clear();
        pulse_start();
        step(14);
        bus_if.stop = 1'b1;
        step(1);
        bus_if.stop = 1'b0;
        check_val("pause_run", {31'd0, bus_if.run}, 32'd0);
        step(20);
        check_val("pause_hold", {16'd0, bus_if.count}, 32'h0003);
        pulse_start();
        check_val("resume_run", {31'd0, bus_if.run}, 32'd1);
        step(1);
        check_val("resume_e1", {16'd0, bus_if.count}, 32'h0003);
        step(1);
        check_val("resume_e2", {16'd0, bus_if.count}, 32'h0004);
        check_val("resume_tick", {31'd0, bus_if.tick}, 32'd1);

        // A stop sampled with the prescaler at its last value suppresses the increment
        step(3);
        bus_if.stop = 1'b1;
        step(1);
        bus_if.stop = 1'b0;
        check_val("stop_last_cnt",  {16'd0, bus_if.count}, 32'h0004);
        check_val("stop_last_tick", {31'd0, bus_if.tick}, 32'd0);
        pulse_start();
        check_val("res_last_e0", {16'd0, bus_if.count}, 32'h0004);
        step(1);
        check_val("res_last_e1", {16'd0, bus_if.count}, 32'h0005);
        check_val("res_last_tick", {31'd0, bus_if.tick}, 32'd1);

        // Control priority
        bus_if.clear = 1'b1;
        bus_if.start = 1'b1;
        step(1);
        bus_if.clear = 1'b0;
        bus_if.start = 1'b0;
        check_val("clr_start_run", {31'd0, bus_if.run}, 32'd0);
        check_val("clr_start_cnt", {16'd0, bus_if.count}, 32'h0);
        pulse_start();
        check_val("restart_run", {31'd0, bus_if.run}, 32'd1);
        bus_if.stop  = 1'b1;
        bus_if.start = 1'b1;
        step(1);
        check_val("stop_start_run", {31'd0, bus_if.run}, 32'd0);
        step(3);
        check_val("pause_both_run",  {31'd0, bus_if.run}, 32'd0);
        check_val("pause_both_done", {31'd0, bus_if.done}, 32'd0);
        bus_if.stop  = 1'b0;
        bus_if.start = 1'b0;

        // Terminal count 9999
        pulse_clear();
        pulse_start();
        done_k = 0;
        for (int k = 1; k <= 40100 && done_k == 0; k++) begin
            step(1);
            if (bus_if.done) done_k = k;
        end
        check_val("term_edge",  done_k, 39996);
        check_val("term_count", {16'd0, bus_if.count}, 32'h9999);
        check_val("term_run",   {31'd0, bus_if.run}, 32'd0);
        check_val("term_tick",  {31'd0, bus_if.tick}, 32'd1);
        errs = 0;
        bus_if.start = 1'b1;
        for (int k = 0; k < 100; k++) begin
            step(1);
            if (bus_if.tick || bus_if.count != 16'h9999 || !bus_if.done || bus_if.run)
                errs++;
        end
        bus_if.start = 1'b0;
        check_val("term_hold", errs, 0);
        pulse_clear();
        check_val("term_clr_done", {31'd0, bus_if.done}, 32'd0);
        check_val("term_clr_cnt",  {16'd0, bus_if.count}, 32'h0);

        // Display scan at 0x1234, then at 0x0042
        run_to(1234);
        check_val("scan_cnt", {16'd0, bus_if.count}, 32'h1234);
        scan8(4'b0111, 16'h7BDE, 16'h1234);
        run_to(42);
        check_val("scan_cnt42", {16'd0, bus_if.count}, 32'h0042);
`ifdef BCD_COUNT_CTRL_BLANK_EN
        scan8(4'b1111, 16'hFFDE, 16'hFF42);
`else
        scan8(4'b0111, 16'h7BDE, 16'h0042);
`endif

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bcd_count_ctrl.md
# bcd_count_ctrl

Controller for a four-digit synchronous BCD counting chain and its shared display path. It owns the run/pause/clear/terminal sequencing and prescales the board clock into count ticks. It cascades BCD carries across four digits. It time-multiplexes the single BCD-to-7-segment decoder across four anodes.

## Interface
- `TICK_DIV`, default 100_000_000: clk cycles per count tick; legal range ≥ 2.
- `SCAN_DIV`, default 100_000: clk cycles per display digit slot; legal range ≥ 2.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  level, sampled each edge: begin or resume counting.
- `stop`  in  1  level, sampled each edge: pause counting.
- `clear`  in  1  level, sampled each edge: return to idle with count zero.
- `run`  out  1  high while in RUN.
- `done`  out  1  high while in DONE.
- `tick`  out  1  one-cycle pulse, coincident with each count increment.
- `count`  out  16  four BCD digits; [3:0] is the ones digit.
- `digit_sel`  out  4  active-low one-hot anode enable.
- `digit_bcd`  out  4  BCD value routed to the shared decoder.

## Operation
- **States:** IDLE, RUN, PAUSE, DONE. State, prescaler, count, scan counter and scan index are registers.
- **Priority per edge:** clear > stop > start.
- **clear, any state:**
  - state goes to IDLE.
  - count and tick prescaler go to 0.
  - scan logic is unaffected.
- **Transitions:**
  - IDLE + start → RUN.
  - RUN + stop → PAUSE; start is ignored if stop is also high.
  - PAUSE + start (no stop) → RUN.
  - DONE ignores start and stop; only clear or reset exits DONE.
- **Tick prescaler:**
  - Counts 0..TICK_DIV-1, only while the registered state is RUN.
  - Holds its value in PAUSE, so a resume continues the partial period.
  - Zeroed on clear, on reset, and on the IDLE→RUN edge.
  - Width is $clog2(TICK_DIV).
- **Increment edge** (state RUN, prescaler == TICK_DIV-1):
  - prescaler → 0.
  - count → BCD count+1.
  - tick register → 1; it is 0 on all other edges.
- **BCD arithmetic:**
  - Ones digit 9→0 carries into tens, and so on.
  - A digit increments only if every lower digit was 9.
  - A digit value above 9 never appears.
- **Terminal count:** the increment that produces 9999 also moves the state RUN→DONE on the same edge. count holds 9999 and no further ticks occur.
- **Scan prescaler:**
  - Counts 0..SCAN_DIV-1 continuously in every state.
  - On wrap, the scan index advances 0→1→2→3→0.
- **Display outputs:**
  - digit_sel = ~(1 << idx), registered.
  - digit_bcd = count digit idx, combinational from registered idx and count.
- **Outputs are pure functions of state:** run = (state==RUN); done = (state==DONE).
- **Reset values:**
  - state IDLE; run 0; done 0; tick 0.
  - count 16'h0000.
  - idx 0; digit_sel 4'b1110; digit_bcd 4'h0.
  - both prescalers 0.
- **Reset mid-operation:** same result as the reset values above, regardless of state or prescaler value.

## Timing
- With no pause, the first increment occurs exactly TICK_DIV edges after the edge that samples start in IDLE. Later increments occur every TICK_DIV edges.
- Resume from PAUSE with prescaler p: the next increment occurs TICK_DIV-p edges after the resume edge.
- stop sampled on an edge where the prescaler is at TICK_DIV-1: stop wins, and no increment occurs.
- count, tick, run and done change only on clk edges. Their latency from a sampled control input is one edge.
- Each digit slot lasts exactly SCAN_DIV cycles. A full refresh takes 4×SCAN_DIV cycles.

## Configuration
- Macro: `BCD_COUNT_CTRL_BLANK_EN`.
- **Defined:** leading-zero blanking.
  - Digit i (i = 1..3) is blank when it and all higher digits are 0.
  - In a blanked slot, digit_sel = 4'b1111 and digit_bcd = 4'hF.
  - Digit 0 is never blanked.
- **Undefined:** all four digits are always driven. digit_sel follows the one-hot pattern unconditionally.

## Test plan
All scenarios use TICK_DIV=4 and SCAN_DIV=2.
1. **Reset:** reset=0 for 2 edges mid-RUN at count 0x0037 → count 0x0000, run 0, done 0, tick 0, digit_sel 1110 on the next cycle.
2. **Counting:** start pulse in IDLE, then 40 edges → count 0x0010. tick pulses 10 times, exactly 4 edges apart. count 0x0009→0x0010 and 0x0099→0x0100 each occur in one edge.
3. **Terminal:** run to 9999 → done=1 and run=0 on the producing edge. count stays 0x9999 and tick stays 0 for 100 more cycles. start is ignored. clear → IDLE, count 0x0000.
4. **Pause/resume:** stop at count 0x0003 with prescaler 2, then wait 20 edges → count is unchanged. Then start → count becomes 0x0004 exactly 2 edges after the resume edge.
5. **Priority:**
   - clear+start in RUN → IDLE, count 0.
   - stop+start in RUN → PAUSE.
   - start+stop in PAUSE → stays PAUSE.
6. **Scan:**
   - digit_sel cycles 1110, 1101, 1011, 0111, each for 2 cycles, with digit_bcd equal to the matching digit of 0x1234.
   - With `BCD_COUNT_CTRL_BLANK_EN` and count 0x0042: slots 2 and 3 give 1111/F; slots 0 and 1 show 2 and 4.
